// File: rtl/core_regbank_banked.sv
// core_regbank_banked: Cortex-M0 style register bank with banked SP and exception stacking sequencer
module core_regbank_banked #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3,
  parameter logic [DATA_W-1:0] LR_RST = '1,
  parameter logic [DATA_W-1:0] MSP_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  input  logic                     wa_en,
  input  logic [3:0]               wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [3:0]               wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     pc_ld,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     apsr_ld,
  input  logic [3:0]               apsr_in,
  input  logic                     primask_ld,
  input  logic                     primask_in,
  input  logic                     spsel_ld,
  input  logic                     spsel_in,
  input  logic                     exc_req,
  input  logic [5:0]               exc_num,
  input  logic                     exc_ret,
  input  logic [3:0]               exc_ret_val,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        r_sp,
  output logic [DATA_W-1:0]        r_pc,
  output logic [DATA_W-1:0]        r_lr,
  output logic [3:0]               r_apsr,
  output logic [5:0]               r_ipsr,
  output logic                     r_primask,
  output logic                     r_spsel,
  output logic                     handler_mode
);
  typedef enum logic [1:0] {IDLE, PUSH, POP, DONE} state_t;
  localparam logic [DATA_W-1:0] WSZ = DATA_W'(DATA_W / 8);
  localparam logic [DATA_W-1:0] FRAME = WSZ << 3;
  state_t state, state_nx;
  logic [DATA_W-1:0] r [13];
  logic [DATA_W-1:0] view [16];
  logic [DATA_W-1:0] wd [16];
  logic [15:0] we;
  logic [DATA_W-1:0] msp, psp, lr, pc, base, ret_lr, act_sp, xpsr, sp_fin;
  logic [3:0] apsr, pop_reg;
  logic [5:0] ipsr, exc_no;
  logic [2:0] idx;
  logic primask, spsel, bank, idle, use_psp, ack, fin;
  assign idle = state == IDLE;
  assign use_psp = spsel && ipsr == '0;
  assign act_sp = use_psp ? psp : msp;
  assign xpsr = {apsr, {(DATA_W-10){1'b0}}, ipsr};
  assign ack = mem_req && mem_ack;
  assign fin = ack && idx == 3'd7;
  assign sp_fin = state == PUSH ? base : base + FRAME;
  assign pop_reg = idx[2] ? (idx[1] ? 4'd15 : (idx[0] ? 4'd14 : 4'd12)) : {2'b00, idx[1:0]};
  assign busy = !idle;
  assign seq_done = state == DONE;
  assign mem_req = state == PUSH || state == POP;
  assign mem_we = state == PUSH;
  assign mem_addr = mem_req ? base + DATA_W'(idx) * WSZ : '0;
  assign mem_wdata = mem_we ? (idx == 3'd7 ? xpsr : view[pop_reg]) : '0;
  assign r_sp = act_sp;
  assign r_pc = pc;
  assign r_lr = lr;
  assign r_apsr = apsr;
  assign r_ipsr = ipsr;
  assign r_primask = primask;
  assign r_spsel = spsel;
  assign handler_mode = ipsr != '0;
  always_comb begin
    for (int i = 0; i < 13; i++) view[i] = r[i];
    view[13] = act_sp;
    view[14] = lr;
    view[15] = pc;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [3:0] a;
    assign a = rd_addr[4*k +: 4];
    assign rd_data[DATA_W*k +: DATA_W] = idle && wb_en && wb_addr == a ? wb_data :
                                         idle && wa_en && wa_addr == a ? wa_data : view[a];
  end
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      we[i] = idle && i != 15 && (wb_en && wb_addr == 4'(i) || wa_en && wa_addr == 4'(i));
      wd[i] = wb_en && wb_addr == 4'(i) ? wb_data : wa_data;
    end
    if (state == POP && ack && idx != 3'd7) begin
      we[pop_reg] = 1'b1;
      wd[pop_reg] = mem_rdata;
    end
  end
  always_comb state_nx = idle ? (exc_req ? PUSH : (exc_ret ? POP : IDLE)) :
                         state == DONE ? IDLE : (fin ? DONE : state);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 13; i++) r[i] <= '0;
      msp <= MSP_RST;
      psp <= '0;
      lr <= LR_RST;
      pc <= '0;
      apsr <= '0;
      ipsr <= '0;
      primask <= 1'b0;
      spsel <= 1'b0;
      base <= '0;
      ret_lr <= '0;
      exc_no <= '0;
      bank <= 1'b0;
      idx <= '0;
    end else begin
      for (int i = 0; i < 13; i++) if (we[i]) r[i] <= wd[i];
      if (we[14]) lr <= wd[14];
      if (we[15]) pc <= wd[15];
      if (idle && pc_ld) pc <= pc_in;
      if (we[13] && use_psp) psp <= wd[13] & ~DATA_W'(3);
      if (we[13] && !use_psp) msp <= wd[13] & ~DATA_W'(3);
      if (idle && apsr_ld) apsr <= apsr_in;
      if (idle && primask_ld) primask <= primask_in;
      if (idle && spsel_ld) spsel <= spsel_in;
      if (idle && exc_req) begin
        base <= act_sp - FRAME;
        bank <= use_psp;
        exc_no <= exc_num;
        ret_lr <= {{(DATA_W-4){1'b1}}, ipsr != '0 ? 4'h1 : (use_psp ? 4'hD : 4'h9)};
        idx <= '0;
      end else if (idle && exc_ret) begin
        base <= exc_ret_val == 4'hD ? psp : msp;
        bank <= exc_ret_val == 4'hD;
        idx <= '0;
      end
      if (ack) idx <= idx + 3'd1;
      if (fin && bank) psp <= sp_fin;
      if (fin && !bank) msp <= sp_fin;
      if (fin && state == PUSH) begin
        lr <= ret_lr;
        ipsr <= exc_no;
      end
      if (fin && state == POP) begin
        apsr <= mem_rdata[DATA_W-1 -: 4];
        ipsr <= mem_rdata[5:0];
        spsel <= bank;
      end
    end
  end
endmodule

// File: tb/tb_core_regbank_banked.sv
// tb_core_regbank_banked: table, directed and randomized checks of core_regbank_banked against a behavioural model
module tb_core_regbank_banked;
  logic clk = 1'b0;
  logic rst;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic wa_en, wb_en, pc_ld, apsr_ld, primask_ld, primask_in, spsel_ld, spsel_in, exc_req, exc_ret;
  logic [3:0] wa_addr, wb_addr, apsr_in, exc_ret_val;
  logic [31:0] wa_data, wb_data, pc_in, mem_addr, mem_wdata, mem_rdata, r_sp, r_pc, r_lr;
  logic [5:0] exc_num, r_ipsr;
  logic busy, seq_done, mem_req, mem_we, mem_ack, r_primask, r_spsel, handler_mode;
  logic [3:0] r_apsr;
  int n_err = 0, n_chk = 0;
  logic [31:0] m_r [16];
  logic [31:0] m_msp, m_psp;
  logic [3:0] m_apsr;
  logic [5:0] m_ipsr;
  logic m_pm, m_spsel;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_a [8];
  logic [31:0] exp_d [8];
  logic [31:0] log_a [8];
  logic [31:0] log_d [8];
  logic log_we [8];
  int nw, stable_bad;
  logic [3:0] ret_q [$];
  typedef struct {
    logic wa_en; logic [3:0] wa_a; logic [31:0] wa_d;
    logic wb_en; logic [3:0] wb_a; logic [31:0] wb_d;
    logic [3:0] ra; logic [31:0] exp_now; logic [3:0] ra2; logic [31:0] exp_next;
  } vec_t;
  vec_t tbl [8];
  always #5 clk = ~clk;
  core_regbank_banked dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_ld(pc_ld), .pc_in(pc_in), .apsr_ld(apsr_ld), .apsr_in(apsr_in),
    .primask_ld(primask_ld), .primask_in(primask_in), .spsel_ld(spsel_ld), .spsel_in(spsel_in),
    .exc_req(exc_req), .exc_num(exc_num), .exc_ret(exc_ret), .exc_ret_val(exc_ret_val),
    .busy(busy), .seq_done(seq_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .r_sp(r_sp), .r_pc(r_pc), .r_lr(r_lr), .r_apsr(r_apsr), .r_ipsr(r_ipsr),
    .r_primask(r_primask), .r_spsel(r_spsel), .handler_mode(handler_mode)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    wa_en = 0; wa_addr = 0; wa_data = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    pc_ld = 0; pc_in = 0; apsr_ld = 0; apsr_in = 0; primask_ld = 0; primask_in = 0;
    spsel_ld = 0; spsel_in = 0; exc_req = 0; exc_num = 0; exc_ret = 0; exc_ret_val = 0;
    mem_ack = 0; rd_addr = 0;
  endtask
  task automatic m_reset;
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_r[14] = 32'hFFFF_FFFF;
    m_msp = 0; m_psp = 0; m_apsr = 0; m_ipsr = 0; m_pm = 0; m_spsel = 0;
  endtask
  function automatic bit m_on_psp();
    return m_spsel && m_ipsr == 6'd0;
  endfunction
  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd13) return m_on_psp() ? m_psp : m_msp;
    return m_r[a];
  endfunction
  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return m_read(a);
  endfunction
  task automatic m_write(input logic [3:0] a, input logic [31:0] d);
    if (a == 4'd13) begin
      if (m_on_psp()) m_psp = d & 32'hFFFF_FFFC;
      else m_msp = d & 32'hFFFF_FFFC;
    end else if (a != 4'd15) m_r[a] = d;
  endtask
  task automatic m_cycle;
    if (wa_en) m_write(wa_addr, wa_data);
    if (wb_en) m_write(wb_addr, wb_data);
    if (pc_ld) m_r[15] = pc_in;
    if (apsr_ld) m_apsr = apsr_in;
    if (primask_ld) m_pm = primask_in;
    if (spsel_ld) m_spsel = spsel_in;
  endtask
  task automatic m_entry(input logic [5:0] num);
    bit up;
    logic [31:0] b;
    up = m_on_psp();
    b = (up ? m_psp : m_msp) - 32'd32;
    exp_d = '{m_r[0], m_r[1], m_r[2], m_r[3], m_r[12], m_r[14], m_r[15], {m_apsr, 22'd0, m_ipsr}};
    for (int i = 0; i < 8; i++) exp_a[i] = b + 32'(4 * i);
    m_r[14] = m_ipsr != 6'd0 ? 32'hFFFF_FFF1 : (up ? 32'hFFFF_FFFD : 32'hFFFF_FFF9);
    if (up) m_psp = b;
    else m_msp = b;
    m_ipsr = num;
  endtask
  task automatic m_return(input logic [3:0] val);
    bit up;
    logic [31:0] b;
    int dst [7] = '{0, 1, 2, 3, 12, 14, 15};
    up = val == 4'hD;
    b = up ? m_psp : m_msp;
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = b + 32'(4 * i);
      exp_d[i] = mem.exists(exp_a[i]) ? mem[exp_a[i]] : 32'h0;
    end
    for (int i = 0; i < 7; i++) m_r[dst[i]] = exp_d[i];
    m_apsr = exp_d[7][31:28];
    m_ipsr = exp_d[7][5:0];
    if (up) m_psp = b + 32'd32;
    else m_msp = b + 32'd32;
    m_spsel = up;
  endtask
  task automatic check_arch;
    chk("r_sp", r_sp, m_read(4'd13));
    chk("r_pc", r_pc, m_r[15]);
    chk("r_lr", r_lr, m_r[14]);
    chk("r_apsr", 32'(r_apsr), 32'(m_apsr));
    chk("r_ipsr", 32'(r_ipsr), 32'(m_ipsr));
    chk("r_primask", 32'(r_primask), 32'(m_pm));
    chk("r_spsel", 32'(r_spsel), 32'(m_spsel));
    chk("handler_mode", 32'(handler_mode), 32'(m_ipsr != 6'd0));
  endtask
  task automatic check_regs;
    for (int a = 0; a < 16; a += 3) begin
      for (int k = 0; k < 3; k++) rd_addr[4*k +: 4] = 4'((a + k) % 16);
      #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("reg%0d", (a + k) % 16), rd_data[32*k +: 32], m_read(4'((a + k) % 16)));
    end
    rd_addr = 0;
  endtask
  task automatic serve(input int dly, output int cyc);
    logic [31:0] ha;
    int cnt;
    bit fresh;
    cyc = 0; nw = 0; stable_bad = 0; cnt = 0; fresh = 1; ha = 0;
    while (!seq_done && cyc < 400) begin
      mem_ack = 0;
      if (mem_req) begin
        if (fresh) begin
          ha = mem_addr;
          cnt = 0;
          fresh = 0;
        end else if (mem_addr !== ha) stable_bad++;
        if (cnt == dly) begin
          mem_ack = 1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          if (nw < 8) begin
            log_a[nw] = mem_addr;
            log_we[nw] = mem_we;
            log_d[nw] = mem_we ? mem_wdata : mem_rdata;
          end
          nw++;
          fresh = 1;
        end
        cnt++;
      end
      step;
      cyc++;
    end
    mem_ack = 0;
  endtask
  task automatic do_seq(input bit entry, input logic [5:0] num, input logic [3:0] val, input int dly, input bit collide);
    int cyc;
    clr;
    if (entry) m_entry(num);
    else m_return(val);
    exc_req = entry || collide;
    exc_ret = !entry || collide;
    exc_num = num;
    exc_ret_val = val;
    step;
    exc_req = 0;
    exc_ret = 0;
    chk("busy_rise", 32'(busy), 32'd1);
    if (collide) begin
      wa_en = 1; wa_addr = 0; wa_data = 32'hDEAD_BEEF;
    end
    serve(dly, cyc);
    wa_en = 0;
    chk("seq_cycles", 32'(cyc), 32'(8 * (dly + 1)));
    chk("seq_done_high", 32'(seq_done), 32'd1);
    chk("word_count", 32'(nw), 32'd8);
    chk("addr_stable", 32'(stable_bad), 32'd0);
    for (int i = 0; i < 8 && i < nw; i++) begin
      chk($sformatf("w%0d_addr", i), log_a[i], exp_a[i]);
      chk($sformatf("w%0d_we", i), 32'(log_we[i]), 32'(entry));
      chk($sformatf("w%0d_data", i), log_d[i], exp_d[i]);
    end
    step;
    chk("seq_done_pulse", 32'(seq_done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    check_arch;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    clr;
    mem_rdata = 0;
    rst = 1;
    m_reset;
    step;
    step;
    rst = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    check_arch;
    check_regs;
    wa_en = 1; wa_addr = 0; wa_data = 32'h55; pc_ld = 1; pc_in = 32'h80;
    step;
    clr;
    exc_req = 1; exc_num = 6'd2;
    step;
    exc_req = 0;
    step;
    chk("mid_busy", 32'(busy), 32'd1);
    #3 rst = 1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_lr", r_lr, 32'hFFFF_FFFF);
    chk("arst_pc", r_pc, 32'd0);
    chk("arst_r0", rd_data[31:0], 32'd0);
    step;
    step;
    rst = 0;
    m_reset;
    check_arch;
    tbl[0] = '{1'b1, 4'd3, 32'd5, 1'b1, 4'd3, 32'd9, 4'd3, 32'd9, 4'd3, 32'd9};
    tbl[1] = '{1'b1, 4'd1, 32'h11, 1'b0, 4'd0, 32'd0, 4'd1, 32'h11, 4'd1, 32'h11};
    tbl[2] = '{1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h22, 4'd2, 32'h22, 4'd2, 32'h22};
    tbl[3] = '{1'b1, 4'd4, 32'h44, 1'b1, 4'd5, 32'h55, 4'd5, 32'h55, 4'd4, 32'h44};
    tbl[4] = '{1'b1, 4'd15, 32'h1234, 1'b0, 4'd0, 32'd0, 4'd3, 32'd9, 4'd15, 32'd0};
    tbl[5] = '{1'b0, 4'd0, 32'd0, 1'b1, 4'd13, 32'h103, 4'd1, 32'h11, 4'd13, 32'h100};
    tbl[6] = '{1'b1, 4'd12, 32'hC, 1'b0, 4'd0, 32'd0, 4'd12, 32'hC, 4'd12, 32'hC};
    tbl[7] = '{1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd14, 32'hFFFF_FFFF, 4'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      clr;
      wa_en = tbl[i].wa_en; wa_addr = tbl[i].wa_a; wa_data = tbl[i].wa_d;
      wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_a; wb_data = tbl[i].wb_d;
      rd_addr[3:0] = tbl[i].ra;
      #1;
      chk($sformatf("tbl%0d_now", i), rd_data[31:0], tbl[i].exp_now);
      m_cycle;
      step;
      clr;
      rd_addr[3:0] = tbl[i].ra2;
      #1;
      chk($sformatf("tbl%0d_next", i), rd_data[31:0], tbl[i].exp_next);
    end
    clr;
    wb_en = 1; wb_addr = 13; wb_data = 32'h2000_0100;
    m_cycle; step; clr;
    spsel_ld = 1; spsel_in = 1;
    m_cycle; step; clr;
    wa_en = 1; wa_addr = 13; wa_data = 32'h2000_0203;
    m_cycle; step; clr;
    chk("bank_psp", r_sp, 32'h2000_0200);
    chk("bank_spsel", 32'(r_spsel), 32'd1);
    spsel_ld = 1; spsel_in = 0;
    m_cycle; step; clr;
    chk("bank_msp", r_sp, 32'h2000_0100);
    check_arch;
    wb_en = 1; wb_addr = 13; wb_data = 32'h100;
    m_cycle; step; clr;
    wa_en = 1; wa_addr = 0; wa_data = 1; wb_en = 1; wb_addr = 1; wb_data = 2;
    m_cycle; step; clr;
    wa_en = 1; wa_addr = 2; wa_data = 3; wb_en = 1; wb_addr = 3; wb_data = 4;
    pc_ld = 1; pc_in = 32'h400; apsr_ld = 1; apsr_in = 4'hA;
    m_cycle; step; clr;
    do_seq(1, 6'd3, 4'h0, 0, 0);
    chk("entry_w0_addr", log_a[0], 32'hE0);
    chk("entry_w7_addr", log_a[7], 32'hFC);
    chk("entry_w0_r0", log_d[0], 32'd1);
    chk("entry_xpsr", log_d[7], 32'hA000_0000);
    chk("entry_sp", r_sp, 32'hE0);
    chk("entry_lr", r_lr, 32'hFFFF_FFF9);
    chk("entry_ipsr", 32'(r_ipsr), 32'd3);
    wa_en = 1; wa_addr = 0; wa_data = 32'h77; wb_en = 1; wb_addr = 1; wb_data = 32'h88;
    m_cycle; step; clr;
    wa_en = 1; wa_addr = 2; wa_data = 32'h99; wb_en = 1; wb_addr = 3; wb_data = 32'hAA;
    pc_ld = 1; pc_in = 32'h999;
    m_cycle; step; clr;
    do_seq(0, 6'd0, 4'h9, 0, 0);
    chk("ret_sp", r_sp, 32'h100);
    chk("ret_ipsr", 32'(r_ipsr), 32'd0);
    chk("ret_pc", r_pc, 32'h400);
    rd_addr[3:0] = 4'd2;
    #1;
    chk("ret_r2", rd_data[31:0], 32'd3);
    check_regs;
    do_seq(1, 6'd5, 4'h9, 3, 1);
    chk("coll_ipsr", 32'(r_ipsr), 32'd5);
    chk("coll_we", 32'(log_we[3]), 32'd1);
    check_regs;
    do_seq(0, 6'd0, 4'h9, 1, 0);
    check_regs;
    for (int it = 0; it < 400; it++) begin
      int sel;
      sel = $urandom_range(0, 29);
      if (sel == 0 && ret_q.size() < 4) begin
        do_seq(1, 6'($urandom_range(1, 63)), 4'h0, $urandom_range(0, 2), 0);
        ret_q.push_back(m_r[14][3:0]);
      end else if (sel == 1 && ret_q.size() > 0) begin
        do_seq(0, 6'd0, ret_q.pop_back(), $urandom_range(0, 2), 0);
      end else begin
        clr;
        wa_en = 1'($urandom_range(0, 1)); wa_addr = 4'($urandom_range(0, 15)); wa_data = $urandom;
        wb_en = 1'($urandom_range(0, 1)); wb_addr = 4'($urandom_range(0, 15)); wb_data = $urandom;
        pc_ld = $urandom_range(0, 3) == 0; pc_in = $urandom;
        apsr_ld = $urandom_range(0, 3) == 0; apsr_in = 4'($urandom);
        primask_ld = $urandom_range(0, 3) == 0; primask_in = 1'($urandom);
        spsel_ld = $urandom_range(0, 3) == 0; spsel_in = 1'($urandom);
        mem_ack = 1'($urandom_range(0, 1));
        rd_addr = 12'($urandom);
        #1;
        for (int k = 0; k < 3; k++)
          chk($sformatf("rnd_rd%0d", k), rd_data[32*k +: 32], exp_rd(rd_addr[4*k +: 4]));
        m_cycle;
        step;
        clr;
        check_arch;
        chk("rnd_mem_req", 32'(mem_req), 32'd0);
      end
    end
    check_regs;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
